// File: rtl/ospi_flash_ctrl_if.sv
// Host request/response port of the OSPI flash command sequencer.
//   master : request source (drives req_*, observes ready/response/busy)
//   slave  : the sequencer (observes req_*, drives ready/response/busy)
interface ospi_flash_ctrl_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [CNT_W-1:0]  req_count;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_count,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_count,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/ospi_flash_ctrl.sv
// Host-side command sequencer for the OSPI flash model: accepts read/write/erase
// requests, drives the flash strobe interface and returns one response per request.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   bus (slave)         request/response handshake (see ospi_flash_ctrl_if)
//   hold_req            host hold request; gates flash enables via a guard counter
//   flash_*             strobe interface to the flash (cs active-low, registered)
//   flash_data_out      registered read data from the flash
//   flash_hold_n        combinational ~hold_req
// Configuration: define OSPI_CTRL_VERIFY_EN to read back and compare every write.
module ospi_flash_ctrl #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned HOLD_GUARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    ospi_flash_ctrl_if.slave  bus,
    input  logic              hold_req,
    output logic              flash_cs,
    output logic              flash_write_enable,
    output logic              flash_read_enable,
    output logic              flash_erase_enable,
    output logic [ADDR_W-1:0] flash_address,
    output logic [DATA_W-1:0] flash_data_in,
    input  logic [DATA_W-1:0] flash_data_out,
    output logic              flash_hold_n
);
    localparam int unsigned GUARD_W = $clog2(HOLD_GUARD + 1);
    localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(HOLD_GUARD);
    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_ERASE   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RELEASE
`ifdef OSPI_CTRL_VERIFY_EN
        ,
        ST_VFY_ACCESS,
        ST_VFY_CAPTURE
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic                hold_ok, hold_ok_d;
    logic                cs_q, cs_d;
    logic                we_q, we_d, re_q, re_d, ee_q, ee_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;

    // Consecutive hold-free cycles, saturating at HOLD_GUARD.
    always_comb begin
        guard_d = guard_q;
        if (hold_req) begin
            guard_d = '0;
        end else if (guard_q != GUARD_MAX) begin
            guard_d = guard_q + GUARD_W'(1);
        end
    end

    assign hold_ok   = (guard_q == GUARD_MAX);
    assign hold_ok_d = (guard_d == GUARD_MAX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and request/erase bookkeeping.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    count_d = bus.req_count;
                    state_d = (bus.req_op == OP_ILLEGAL) ? ST_RELEASE : ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // A stalled cycle issues no enable, so nothing advances.
                if (hold_ok) begin
                    case (op_q)
                        OP_READ:  state_d = ST_CAPTURE;
`ifdef OSPI_CTRL_VERIFY_EN
                        OP_WRITE: state_d = ST_VFY_ACCESS;
`else
                        OP_WRITE: state_d = ST_RELEASE;
`endif
                        OP_ERASE: begin
                            addr_d  = addr_q + ADDR_W'(1);
                            count_d = count_q - CNT_W'(1);
                            if (count_q == '0) begin
                                state_d = ST_RELEASE;
                            end
                        end
                        default:  state_d = ST_RELEASE;
                    endcase
                end
            end
            ST_CAPTURE: state_d = ST_RELEASE;
`ifdef OSPI_CTRL_VERIFY_EN
            ST_VFY_ACCESS: begin
                if (hold_ok) begin
                    state_d = ST_VFY_CAPTURE;
                end
            end
            ST_VFY_CAPTURE: state_d = ST_RELEASE;
`endif
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered: decode the state being entered.
    always_comb begin
        cs_d        = 1'b1;
        we_d        = 1'b0;
        re_d        = 1'b0;
        ee_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        case (state_d)
            ST_SETUP, ST_CAPTURE: cs_d = 1'b0;
            ST_ACCESS: begin
                cs_d = 1'b0;
                if (hold_ok_d) begin
                    case (op_d)
                        OP_READ:  re_d = 1'b1;
                        OP_WRITE: we_d = 1'b1;
                        OP_ERASE: ee_d = 1'b1;
                        default:  ;
                    endcase
                end
            end
`ifdef OSPI_CTRL_VERIFY_EN
            ST_VFY_ACCESS: begin
                cs_d = 1'b0;
                re_d = hold_ok_d;
            end
            ST_VFY_CAPTURE: cs_d = 1'b0;
`endif
            ST_RELEASE: rsp_valid_d = 1'b1;
            default:    ;
        endcase
        // Only an illegal op jumps straight from IDLE to RELEASE.
        if (state_q == ST_IDLE && state_d == ST_RELEASE) begin
            rsp_err_d = 1'b1;
        end
        if (state_q == ST_CAPTURE) begin
            rsp_rdata_d = flash_data_out;
        end
`ifdef OSPI_CTRL_VERIFY_EN
        if (state_q == ST_VFY_CAPTURE) begin
            rsp_rdata_d = flash_data_out;
            rsp_err_d   = (flash_data_out != wdata_q);
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            count_q     <= '0;
            guard_q     <= '0;
            cs_q        <= 1'b1;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            ee_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            guard_q     <= guard_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            re_q        <= re_d;
            ee_q        <= ee_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign flash_cs           = cs_q;
    assign flash_write_enable = we_q;
    assign flash_read_enable  = re_q;
    assign flash_erase_enable = ee_q;
    assign flash_address      = addr_q;
    assign flash_data_in      = wdata_q;
    assign flash_hold_n       = ~hold_req;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Bench for ospi_flash_ctrl: flash memory model, protocol monitor, directed
// scenarios and randomized requests checked against a transaction-level model.
module tb_ospi_flash_ctrl;
    localparam int unsigned ADDR_W     = 24;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned HOLD_GUARD = 1;
`ifdef OSPI_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              hold_req;
    logic              flash_cs;
    logic              flash_write_enable;
    logic              flash_read_enable;
    logic              flash_erase_enable;
    logic [ADDR_W-1:0] flash_address;
    logic [DATA_W-1:0] flash_data_in;
    logic [DATA_W-1:0] flash_data_out = '0;
    logic              flash_hold_n;

    ospi_flash_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    ospi_flash_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .HOLD_GUARD(HOLD_GUARD)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .hold_req           (hold_req),
        .flash_cs           (flash_cs),
        .flash_write_enable (flash_write_enable),
        .flash_read_enable  (flash_read_enable),
        .flash_erase_enable (flash_erase_enable),
        .flash_address      (flash_address),
        .flash_data_in      (flash_data_in),
        .flash_data_out     (flash_data_out),
        .flash_hold_n       (flash_hold_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Flash model: 4 KiB window indexed by the low address bits, registered read.
    logic [7:0] fmem [0:4095];
    logic       force_zero = 1'b0;
    always @(posedge clk) begin
        if (flash_write_enable) fmem[flash_address[11:0]] <= flash_data_in;
        if (flash_erase_enable) fmem[flash_address[11:0]] <= 8'hFF;
        if (flash_read_enable)  flash_data_out <= force_zero ? 8'h00 : fmem[flash_address[11:0]];
    end

    // Protocol monitor: one-hot enables, enables only under CS, only after the hold guard.
    int                viol    = 0;
    int                low_run = 0;
    logic [ADDR_W-1:0] erase_log [$];
    always @(negedge clk) begin
        if (reset) begin
            low_run <= 0;
        end else begin
            viol <= viol
                  + int'(($countones({flash_write_enable, flash_read_enable, flash_erase_enable}) > 1))
                  + int'((flash_write_enable | flash_read_enable | flash_erase_enable) && flash_cs)
                  + int'((flash_write_enable | flash_read_enable | flash_erase_enable)
                         && (low_run < int'(HOLD_GUARD)));
            if (flash_erase_enable) erase_log.push_back(flash_address);
            low_run <= hold_req ? 0 : ((low_run < 1000) ? low_run + 1 : low_run);
        end
    end

    // Transaction-level reference model.
    logic [7:0] ref_mem [int];
    logic [7:0] last_rdata;
    logic       hold_pat [0:63];

    function automatic bit cycle_ok(input int c);
        for (int k = c - int'(HOLD_GUARD); k < c; k++) begin
            if (k >= 0 && k < 64 && hold_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Cycles from accept edge to response, given the hold pattern.
    function automatic int exp_latency(input logic [1:0] op, input logic [7:0] cnt);
        int steps;
        int tail;
        if (op == 2'b11) return 1;
        steps = (op == 2'b00) ? 1 : (op == 2'b01) ? (VERIFY ? 2 : 1) : int'(cnt) + 1;
        tail  = (op == 2'b00 || (op == 2'b01 && VERIFY)) ? 2 : 1;
        for (int c = 2; c < 400; c++) begin
            if (cycle_ok(c)) begin
                steps--;
                if (steps == 0) return c + tail;
            end
        end
        return -2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hold();
        for (int i = 0; i < 64; i++) hold_pat[i] = 1'b0;
    endtask

    // Issue one request from IDLE and wait (bounded) for its response.
    task automatic run_txn(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd,
                           input logic [7:0] cnt, output int lat, output logic [7:0] rd,
                           output logic er, output logic cs_low);
        int n;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_count = cnt;
        hold_req      = hold_pat[0];
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; rd = 8'h00; er = 1'b0; cs_low = 1'b0;
        n = 1;
        while (n < 300) begin
            hold_req = (n < 64) ? hold_pat[n] : 1'b0;
            if (!flash_cs) cs_low = 1'b1;
            if (bus.rsp_valid) begin
                lat = n; rd = bus.rsp_rdata; er = bus.rsp_err;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        hold_req = 1'b0;
        repeat (HOLD_GUARD + 1) begin @(posedge clk); #1; end
    endtask

    // Run a request and compare latency/data/error against the model.
    task automatic txn_check(input string tag, input logic [1:0] op, input logic [23:0] addr,
                             input logic [7:0] wd, input logic [7:0] cnt);
        int         lat, elat;
        logic [7:0] rd, erd;
        logic       er, cs_low;
        elat = exp_latency(op, cnt);
        erd  = last_rdata;
        if (op == 2'b00) erd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'hFF;
        if (op == 2'b01 && VERIFY) erd = wd;
        run_txn(op, addr, wd, cnt, lat, rd, er, cs_low);
        check({tag, "_lat"},   32'(lat),   32'(elat));
        check({tag, "_rdata"}, 32'(rd),    32'(erd));
        check({tag, "_err"},   32'(er),    32'(op == 2'b11));
        check({tag, "_cs"},    32'(cs_low), 32'(op != 2'b11));
        if (op == 2'b01) ref_mem[int'(addr)] = wd;
        if (op == 2'b10) begin
            for (int i = 0; i <= int'(cnt); i++) ref_mem[int'(24'(addr + 24'(i)))] = 8'hFF;
        end
        last_rdata = erd;
    endtask

    initial begin
        int   nrsp;
        logic [1:0]  op;
        logic [23:0] addr;
        for (int i = 0; i < 4096; i++) fmem[i] = 8'hFF;
        clear_hold();
        last_rdata    = 8'h00;
        reset         = 1'b1;
        hold_req      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs",      32'(flash_cs), 32'(1));
        check("rst_enables", 32'({flash_write_enable, flash_read_enable, flash_erase_enable}), 32'(0));
        check("rst_rsp",     32'({bus.rsp_valid, bus.rsp_err}), 32'(0));
        check("rst_rdata",   32'(bus.rsp_rdata), 32'(0));
        check("rst_addr",    32'(flash_address), 32'(0));
        check("rst_din",     32'(flash_data_in), 32'(0));
        check("rst_ready",   32'({bus.req_ready, bus.busy}), 32'(2));
        reset = 1'b0;
        hold_req = 1'b1;
        #1;
        check("hold_n", 32'(flash_hold_n), 32'(0));
        hold_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Write then read back.
        txn_check("t1_write", 2'b01, 24'h000010, 8'hA5, 8'h00);
        txn_check("t1_read",  2'b00, 24'h000010, 8'h00, 8'h00);

        // Erase across a byte boundary, then at the top of the address space.
        txn_check("t2_pre",   2'b01, 24'h0000FF, 8'h12, 8'h00);
        erase_log.delete();
        txn_check("t2_erase", 2'b10, 24'h0000FE, 8'h00, 8'h03);
        check("t2_nerase", 32'(erase_log.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            check("t2_eaddr", (i < erase_log.size()) ? 32'(erase_log[i]) : 32'hDEAD,
                  32'(24'h0000FE + 24'(i)));
        end
        txn_check("t2_read",  2'b00, 24'h0000FF, 8'h00, 8'h00);
        erase_log.delete();
        txn_check("t2_wrap",  2'b10, 24'hFFFFFF, 8'h00, 8'h01);
        check("t2_wrap_n",  32'(erase_log.size()), 32'(2));
        check("t2_wrap_a0", (erase_log.size() > 0) ? 32'(erase_log[0]) : 32'hDEAD, 32'h00FFFFFF);
        check("t2_wrap_a1", (erase_log.size() > 1) ? 32'(erase_log[1]) : 32'hDEAD, 32'h00000000);

        // Hold asserted for cycles 1..5 of a read.
        for (int i = 1; i <= 5; i++) hold_pat[i] = 1'b1;
        txn_check("t3_hold_read", 2'b00, 24'h000010, 8'h00, 8'h00);
        clear_hold();

        // Illegal opcode.
        txn_check("t4_illegal", 2'b11, 24'h000010, 8'h77, 8'h00);

        // Reset in the middle of a 10-byte erase.
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_addr = 24'h000500; bus.req_count = 8'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_in_access", 32'({flash_cs, flash_erase_enable}), 32'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_cs",      32'(flash_cs), 32'(1));
        check("t5_enables", 32'({flash_write_enable, flash_read_enable, flash_erase_enable}), 32'(0));
        check("t5_ready",   32'({bus.req_ready, bus.busy, bus.rsp_valid}), 32'(4));
        reset = 1'b0;
        nrsp = 0;
        repeat (12) begin @(posedge clk); #1; nrsp += int'(bus.rsp_valid); end
        check("t5_no_rsp", 32'(nrsp), 32'(0));
        last_rdata = 8'h00;

`ifdef OSPI_CTRL_VERIFY_EN
        // Verified write against a flash that reads back zero.
        begin
            int         lat;
            logic [7:0] rd;
            logic       er, cs_low;
            force_zero = 1'b1;
            run_txn(2'b01, 24'h000020, 8'h3C, 8'h00, lat, rd, er, cs_low);
            force_zero = 1'b0;
            check("t6_lat",   32'(lat), 32'(5));
            check("t6_err",   32'(er),  32'(1));
            check("t6_rdata", 32'(rd),  32'(0));
            ref_mem[32'h20] = 8'h3C;
            last_rdata = 8'h00;
        end
`endif

        // Randomized requests with random hold bursts.
        for (int t = 0; t < 40; t++) begin
            int sel;
            clear_hold();
            for (int i = 1; i < 16; i++) hold_pat[i] = ($urandom_range(0, 5) == 0);
            sel  = int'($urandom_range(0, 9));
            op   = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            addr = ($urandom_range(0, 9) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                               : 24'h000010 + 24'($urandom_range(0, 15));
            txn_check("rnd", op, addr, 8'($urandom), 8'($urandom_range(0, 4)));
        end
        clear_hold();

        check("protocol_violations", 32'(viol), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
